// File: rtl/mul_pipe_pkg.sv
// Shared helpers for the pipelined shift-and-add multiplier.
// - clog2     : ceiling log2, used to size the adder tree.
// - lat_of    : accept-to-result latency for a given operand width.
// - tree_off  : index of the first term of a tree level inside the flat
//               node vector (level 0 = partial products, level k halves).
package mul_pipe_pkg;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  // One cycle for the operand register plus one per adder-tree level.
  function automatic int lat_of(input int width);
    return clog2(width) + 32'sd1;
  endfunction

  // Level k starts after all terms of levels 0..k-1: 2W - 2W/2^k.
  function automatic int tree_off(input int width, input int level);
    return (32'sd2 * width) - ((32'sd2 * width) >>> level);
  endfunction

endpackage

// File: rtl/mul_pp_gen.sv
// Partial-product generator (purely combinational).
// Ports:
//   a_i      multiplicand
//   b_i      multiplier; bit i selects a_ext << i
//   signed_i 1 = two's-complement operands, 0 = unsigned
//   pp_o     WIDTH partial products, each 2*WIDTH bits
// In signed mode the top multiplier bit carries weight -2^(WIDTH-1), so its
// partial product is negated; summing all terms mod 2^(2*WIDTH) then yields
// the signed product.
module mul_pp_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]                a_i,
  input  logic [WIDTH-1:0]                b_i,
  input  logic                            signed_i,
  output logic [WIDTH-1:0][2*WIDTH-1:0]   pp_o
);

  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] a_ext_s;

  // Extend the multiplicand to product width according to the mode.
  always_comb begin
    if (signed_i) begin
      a_ext_s = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    end else begin
      a_ext_s = {{WIDTH{1'b0}}, a_i};
    end
  end

  // Select, shift and (for the signed MSB term) negate each partial product.
  always_comb begin
    pp_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b_i[i]) begin
        if (signed_i && (i == WIDTH - 1)) begin
          pp_o[i] = ~(a_ext_s << i) + ONE;
        end else begin
          pp_o[i] = a_ext_s << i;
        end
      end else begin
        pp_o[i] = '0;
      end
    end
  end

endmodule

// File: rtl/mul_pipe_tree.sv
// Pipelined shift-and-add multiplier with a registered binary adder tree.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = pipeline may advance)
//   mul_a, mul_b          operands, mul_signed selects two's-complement mode
//   in_tag                sideband returned unchanged with the result
//   flush                 synchronous kill of every in-flight operation
//   out_valid / out_ready result handshake; a stall freezes the whole pipe
//   mul_out               product mod 2^(2*WIDTH)
//   out_signed, out_tag   mode and tag of the returned result
// Latency is clog2(WIDTH)+1 cycles; the pipeline moves in lockstep and never
// collapses bubbles. Data, tag and mode registers load zero whenever the
// incoming slot is empty so the outputs read 0 while out_valid is low.
module mul_pipe_tree
  import mul_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mul_a,
  input  logic [WIDTH-1:0]   mul_b,
  input  logic               mul_signed,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] mul_out,
  output logic               out_signed,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int L     = clog2(WIDTH);
  localparam int DW    = 2 * WIDTH;
  localparam int NODES = 2 * WIDTH - 1;

  typedef struct packed {
    logic             valid;
    logic             sgn;
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
  } stage_t;

  logic                         adv_s;
  stage_t                       s1_q;
  stage_t                       s1_d;
  // Flat tree: [WIDTH-1:0] partial products, then each level's sums in turn.
  logic [NODES-1:0][DW-1:0]     node_s;
  logic [L:0]                   vld_s;
  logic [L:0]                   sgn_s;
  logic [L:0][TAG_W-1:0]        tag_s;

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  // Operand stage next state: capture on accept, empty slot otherwise.
  always_comb begin
    s1_d = s1_q;
    if (flush) begin
      s1_d = '0;
    end else if (adv_s) begin
      if (in_valid) begin
        s1_d.valid = 1'b1;
        s1_d.sgn   = mul_signed;
        s1_d.tag   = in_tag;
        s1_d.data  = {mul_a, mul_b};
      end else begin
        s1_d = '0;
      end
    end else begin
      s1_d = s1_q;
    end
  end

  // Operand stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  assign vld_s[0] = s1_q.valid;
  assign sgn_s[0] = s1_q.sgn;
  assign tag_s[0] = s1_q.tag;

  mul_pp_gen #(
    .WIDTH (WIDTH)
  ) u_pp_gen (
    .a_i      (s1_q.data[DW-1:WIDTH]),
    .b_i      (s1_q.data[WIDTH-1:0]),
    .signed_i (s1_q.sgn),
    .pp_o     (node_s[WIDTH-1:0])
  );

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int N   = WIDTH >> k;
    localparam int SRC = tree_off(WIDTH, k - 1);
    localparam int DST = tree_off(WIDTH, k);

    logic [N-1:0][DW-1:0] sum_q;
    logic [N-1:0][DW-1:0] sum_d;
    logic                 vld_q;
    logic                 vld_d;
    logic                 sgn_q;
    logic                 sgn_d;
    logic [TAG_W-1:0]     tag_q;
    logic [TAG_W-1:0]     tag_d;

    // Pairwise sums of the previous level, with mode/tag riding along.
    always_comb begin
      sum_d = sum_q;
      vld_d = vld_q;
      sgn_d = sgn_q;
      tag_d = tag_q;
      if (flush) begin
        sum_d = '0;
        vld_d = 1'b0;
        sgn_d = 1'b0;
        tag_d = '0;
      end else if (adv_s) begin
        if (vld_s[k-1]) begin
          vld_d = 1'b1;
          sgn_d = sgn_s[k-1];
          tag_d = tag_s[k-1];
          for (int j = 0; j < N; j++) begin
            sum_d[j] = node_s[SRC + 2*j] + node_s[SRC + 2*j + 1];
          end
        end else begin
          sum_d = '0;
          vld_d = 1'b0;
          sgn_d = 1'b0;
          tag_d = '0;
        end
      end else begin
        sum_d = sum_q;
        vld_d = vld_q;
        sgn_d = sgn_q;
        tag_d = tag_q;
      end
    end

    // Tree level registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        vld_q <= 1'b0;
        sgn_q <= 1'b0;
        tag_q <= '0;
      end else begin
        sum_q <= sum_d;
        vld_q <= vld_d;
        sgn_q <= sgn_d;
        tag_q <= tag_d;
      end
    end

    assign node_s[DST+N-1:DST] = sum_q;
    assign vld_s[k]            = vld_q;
    assign sgn_s[k]            = sgn_q;
    assign tag_s[k]            = tag_q;
  end

  // The last tree level is the output register.
  assign out_valid  = vld_s[L];
  assign out_signed = sgn_s[L];
  assign out_tag    = tag_s[L];
  assign mul_out    = node_s[NODES-1];

endmodule

// File: tb/tb_mul_pipe_tree.sv
// Self-checking bench for mul_pipe_tree: a queue-based reference model of
// accepted operations predicts what must appear on the output and when,
// plus directed vectors with hand-computed products.
module tb_mul_pipe_tree;

  localparam int W    = 8;
  localparam int TW   = 4;
  localparam int LATV = 4;   // clog2(8) + 1

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, mul_signed, flush;
  logic          out_valid, out_ready, out_signed;
  logic [W-1:0]  mul_a, mul_b;
  logic [TW-1:0] in_tag, out_tag;
  logic [2*W-1:0] mul_out;

  logic          in_valid16, in_ready16, mul_signed16, flush16;
  logic          out_valid16, out_ready16, out_signed16;
  logic [15:0]   mul_a16, mul_b16;
  logic [TW-1:0] in_tag16, out_tag16;
  logic [31:0]   mul_out16;

  always #5 clk = ~clk;

  mul_pipe_tree #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .mul_out(mul_out), .out_signed(out_signed), .out_tag(out_tag)
  );

  mul_pipe_tree #(.WIDTH(16), .TAG_W(TW)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .mul_a(mul_a16), .mul_b(mul_b16), .mul_signed(mul_signed16), .in_tag(in_tag16),
    .flush(flush16), .out_valid(out_valid16), .out_ready(out_ready16),
    .mul_out(mul_out16), .out_signed(out_signed16), .out_tag(out_tag16)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product: plain integer arithmetic, wrapped to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint pa, pb, p;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    p = pa * pb;
    return p[2*W-1:0];
  endfunction

  typedef struct {
    logic [2*W-1:0] prod;
    logic           sgn;
    logic [TW-1:0]  tag;
    int             acc;
    int             stall0;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   stall_total = 0;
  int   pops = 0;
  logic exp_v;
  exp_t e;

  // Model and compare process: runs on the falling edge, where inputs and
  // outputs are stable and the transfers of the next rising edge are known.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_v = 1'b0;
      if (q.size() > 0) begin
        exp_v = (q[0].acc + LATV + (stall_total - q[0].stall0)) <= cyc;
      end
      check("out_valid", out_valid, exp_v);
      check("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (q.size() > 0) begin
          check("mul_out", mul_out, q[0].prod);
          check("out_tag", out_tag, q[0].tag);
          check("out_signed", out_signed, q[0].sgn);
        end
      end else begin
        check("idle_mul_out", mul_out, '0);
        check("idle_out_tag", out_tag, '0);
        check("idle_out_signed", out_signed, 1'b0);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        pops++;
      end
      if (out_valid && !out_ready) stall_total++;
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        e.prod   = ref_mul(mul_a, mul_b, mul_signed);
        e.sgn    = mul_signed;
        e.tag    = in_tag;
        e.acc    = cyc;
        e.stall0 = stall_total;
        q.push_back(e);
      end
    end
  end

  // Offer one op and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [TW-1:0] t);
    logic acc;
    int   n;
    mul_a = a; mul_b = b; mul_signed = s; in_tag = t; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("accept", acc, 1'b1);
  endtask

  // Single op into an idle pipe: check latency and literal product.
  task automatic one_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [TW-1:0] t, input logic [2*W-1:0] exp_p, input string nm);
    int n;
    send(a, b, s, t);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_latency"}, n, LATV);
    check({nm, "_prod"}, mul_out, exp_p);
    check({nm, "_tag"}, out_tag, t);
    check({nm, "_signed"}, out_signed, s);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic w16_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [31:0] exp_p, input string nm);
    int n;
    check({nm, "_in_ready"}, in_ready16, 1'b1);
    mul_a16 = a; mul_b16 = b; mul_signed16 = s; in_tag16 = 4'h9; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 1;
    while (!out_valid16 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_latency"}, n, 5);
    check({nm, "_prod"}, mul_out16, exp_p);
    check({nm, "_tag"}, out_tag16, 4'h9);
    check({nm, "_signed"}, out_signed16, s);
    @(posedge clk); #1;
    check({nm, "_gone"}, out_valid16, 1'b0);
  endtask

  int             p0;
  int             n;
  logic [2*W-1:0] hv;
  logic [TW-1:0]  ht;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mul_a = '0; mul_b = '0; mul_signed = 1'b0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; mul_a16 = '0; mul_b16 = '0; mul_signed16 = 1'b0;
    in_tag16 = '0; flush16 = 1'b0; out_ready16 = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mul_out", mul_out, '0);
    check("rst_out_tag", out_tag, '0);
    check("rst_out_signed", out_signed, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid16", out_valid16, 1'b0);
    check("rst_mul_out16", mul_out16, '0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed products with hand-computed results.
    one_op(8'hFF, 8'hFF, 1'b0, 4'h5, 16'hFE01, "u255x255");
    one_op(8'h80, 8'hFF, 1'b1, 4'h1, 16'h0080, "s_m128xm1");
    one_op(8'h80, 8'h80, 1'b1, 4'h2, 16'h4000, "s_m128xm128");
    one_op(8'h03, 8'hFE, 1'b1, 4'h3, 16'hFFFA, "s_3xm2");
    one_op(8'h00, 8'hAB, 1'b0, 4'h4, 16'h0000, "u_zero");

    // Back-to-back stream, mixed modes, tags 0..15.
    p0 = pops;
    for (int i = 0; i < 16; i++) begin
      send(8'(i * 37 + 11), 8'(200 - i * 29), 1'(i % 2), 4'(i));
    end
    drain();
    check("stream_count", pops - p0, 16);

    // Stall for 5 cycles while results are pending.
    p0 = pops;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(8'(i * 41 + 5), 8'(i * 23 + 100), 1'(i % 2), 4'(i + 8));
        end
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        out_ready = 1'b0;
        hv = mul_out;
        ht = out_tag;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          check("stall_valid", out_valid, 1'b1);
          check("stall_mul_out", mul_out, hv);
          check("stall_tag", out_tag, ht);
          check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", pops - p0, 6);

    // Flush with three ops in flight plus one offered in the flush cycle.
    send(8'd1, 8'd2, 1'b0, 4'h1);
    send(8'd3, 8'd4, 1'b0, 4'h2);
    send(8'd5, 8'd6, 1'b1, 4'h3);
    mul_a = 8'd7; mul_b = 8'd9; in_tag = 4'hA; mul_signed = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("flush_quiet", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    one_op(8'd12, 8'd11, 1'b0, 4'h7, 16'd132, "post_flush");

    // Flush while stalled discards the held result.
    send(8'd10, 8'd10, 1'b0, 4'h3);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("stall_hold_prod", mul_out, 16'd100);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("stall_flush_valid", out_valid, 1'b0);
    check("stall_flush_prod", mul_out, 16'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 20), 8'(i + 3), 1'b0, 4'(i));
    end
    check("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_prod", mul_out, '0);
    check("rst_mid_tag", out_tag, '0);
    check("rst_mid_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", out_valid, 1'b0);
    end
    one_op(8'hFF, 8'h02, 1'b1, 4'hE, 16'hFFFE, "post_rst");

    // WIDTH=16 instance.
    w16_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_umax");
    w16_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16_smin");
    w16_op(16'h8000, 16'hFFFF, 1'b1, 32'h00008000, "w16_sminxm1");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
